// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle for mux_sel_pipe: upstream offer, downstream result, flush and error controls.
// The master drives the inputs and samples the results; the slave is the selector itself.
interface mux_sel_pipe_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned NUM_IN = 8
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  logic                    flush;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic                    sel_err_clr;

  modport master (
    output flush, in_data, in_sel, in_valid, out_ready, sel_err_clr,
    input  in_ready, out_data, out_sel, out_valid, sel_err
  );

  modport slave (
    input  flush, in_data, in_sel, in_valid, out_ready, sel_err_clr,
    output in_ready, out_data, out_sel, out_valid, sel_err
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// Registered N-to-1 channel selector with valid/ready handshake and a two-entry skid buffer.
// All outputs are flop-driven; in_ready does not depend combinationally on out_ready.
module mux_sel_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned NUM_IN = 8
) (
  input logic          clk,
  input logic          rst,
  mux_sel_pipe_if.slave bus
);
  localparam int unsigned SEL_W = $clog2(NUM_IN);

  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic               in_ready_q, out_valid_q;
  logic               sel_err_q, sel_err_d;
  logic [WIDTH-1:0]   cap_data;
  logic               sel_oor;
  logic               accept, consume;

  // Out-of-range selects fall through the loop and capture an all-zero word.
  always_comb begin
    cap_data = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        cap_data = bus.in_data[k*WIDTH +: WIDTH];
      end
    end
    sel_oor = 32'(bus.in_sel) >= NUM_IN;
  end

  assign accept  = bus.in_valid && in_ready_q && !bus.flush;
  assign consume = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    if (bus.flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StFull;
            main_data_d = cap_data;
            main_sel_d  = bus.in_sel;
          end
        end
        StFull: begin
          if (accept && consume) begin
            main_data_d = cap_data;
            main_sel_d  = bus.in_sel;
          end else if (accept) begin
            state_d     = StSkid;
            skid_data_d = cap_data;
            skid_sel_d  = bus.in_sel;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (consume) begin
            state_d     = StFull;
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // A new error in the same cycle as a clear must win.
  always_comb begin
    sel_err_d = sel_err_q;
    if (accept && sel_oor) begin
      sel_err_d = 1'b1;
    end else if (bus.sel_err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_sel_q  <= '0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= (state_d != StSkid);
      out_valid_q <= (state_d != StEmpty);
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_sel   = main_sel_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Drives an 8-channel and a 5-channel selector with identical stimulus and compares both
// against a two-slot FIFO reference model every cycle.
module tb_mux_sel_pipe;
  logic clk;
  logic rst;
  logic [8*64-1:0] din;

  mux_sel_pipe_if #(.WIDTH(64), .NUM_IN(8)) b8 ();
  mux_sel_pipe_if #(.WIDTH(64), .NUM_IN(5)) b5 ();

  mux_sel_pipe #(.WIDTH(64), .NUM_IN(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  mux_sel_pipe #(.WIDTH(64), .NUM_IN(5)) dut5 (.clk(clk), .rst(rst), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] od [2];
  logic [2:0]  osel [2];
  logic        ov [2];
  logic        ordy [2];
  logic        oerr [2];

  always_comb begin
    od[0] = b8.out_data;  od[1] = b5.out_data;
    osel[0] = b8.out_sel; osel[1] = b5.out_sel;
    ov[0] = b8.out_valid; ov[1] = b5.out_valid;
    ordy[0] = b8.in_ready; ordy[1] = b5.in_ready;
    oerr[0] = b8.sel_err; oerr[1] = b5.sel_err;
  end

  // Reference: the block behaves as a FIFO holding at most two entries.
  logic [63:0] md [2][2];
  logic [2:0]  ms [2][2];
  int          occ [2];
  logic        merr [2];
  int          nin [2];

  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic r, input logic f,
                       input logic c);
    b8.in_data = din;            b5.in_data = din[5*64-1:0];
    b8.in_sel = s;               b5.in_sel = s;
    b8.in_valid = v;             b5.in_valid = v;
    b8.out_ready = r;            b5.out_ready = r;
    b8.flush = f;                b5.flush = f;
    b8.sel_err_clr = c;          b5.sel_err_clr = c;
  endtask

  task automatic set_pattern();
    for (int k = 0; k < 8; k++) din[k*64 +: 64] = 64'hA0A0_0000_0000_0000 | 64'(k);
  endtask

  task automatic reset_check(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s d%0d out_valid", tag, d), 64'(ov[d]), 64'd0);
      chk($sformatf("%s d%0d out_data", tag, d), od[d], 64'd0);
      chk($sformatf("%s d%0d out_sel", tag, d), 64'(osel[d]), 64'd0);
      chk($sformatf("%s d%0d sel_err", tag, d), 64'(oerr[d]), 64'd0);
      chk($sformatf("%s d%0d in_ready", tag, d), 64'(ordy[d]), 64'd1);
      occ[d] = 0;
      merr[d] = 1'b0;
    end
  endtask

  // Called at posedge+1: drive, compare against the model, then advance across one edge.
  task automatic step(input logic v, input logic [2:0] s, input logic r, input logic f,
                      input logic c);
    logic acc, con;
    logic [63:0] w;
    drive(v, s, r, f, c);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d in_ready", d), 64'(ordy[d]), 64'(occ[d] < 2));
      chk($sformatf("d%0d out_valid", d), 64'(ov[d]), 64'(occ[d] > 0));
      chk($sformatf("d%0d sel_err", d), 64'(oerr[d]), 64'(merr[d]));
      if (occ[d] > 0) begin
        chk($sformatf("d%0d out_data", d), od[d], md[d][0]);
        chk($sformatf("d%0d out_sel", d), 64'(osel[d]), 64'(ms[d][0]));
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      acc = v && (occ[d] < 2) && !f;
      con = (occ[d] > 0) && r;
      w = (int'(s) < nin[d]) ? din[int'(s)*64 +: 64] : 64'd0;
      if (f) begin
        occ[d] = 0;
      end else begin
        if (con) begin
          md[d][0] = md[d][1];
          ms[d][0] = ms[d][1];
          occ[d]--;
        end
        if (acc) begin
          md[d][occ[d]] = w;
          ms[d][occ[d]] = s;
          occ[d]++;
        end
      end
      if (acc && int'(s) >= nin[d]) merr[d] = 1'b1;
      else if (c) merr[d] = 1'b0;
    end
  endtask

  initial begin
    nin[0] = 8;
    nin[1] = 5;
    rst = 1'b0;
    set_pattern();
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #2 reset_check("por");
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream with the sink always ready.
    for (int k = 0; k < 8; k++) step(1'b1, 3'(k), 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Backpressure into the skid buffer and recovery.
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Out-of-range select, sticky error, clear, and set-beats-clear.
    step(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd7, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b1, 1'b0, 1'b1);

    // Flush while in the skid state with a fresh offer present.
    step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
    step(1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges while in the skid state.
    step(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1 reset_check("async");
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);

    // Random traffic with random channel contents.
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 16; i++) din[i*32 +: 32] = $urandom;
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 6,
           $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised, registered N-to-1 operand/result selector with a valid/ready handshake and a two-entry skid buffer. It generalises the fixed 8:1 64-bit ALU select to any width and channel count. It adds out-of-range select detection, synchronous flush and full-throughput backpressure, so it can sit on a pipeline-stage boundary (EX result select into EX/MEM). Every output comes from a flop, and there is no combinational path from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, 64, bit width of each channel and of `out_data`
- `NUM_IN`, 8, number of input channels (≥2, need not be a power of two)
- `SEL_W`, `$clog2(NUM_IN)`, select width (localparam, derived)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous discard of all buffered entries
- `in_data`  in  `NUM_IN*WIDTH`  channel k at `[k*WIDTH +: WIDTH]`
- `in_sel`  in  `SEL_W`  channel index to capture
- `in_valid`  in  1  upstream offers `in_data`/`in_sel`
- `in_ready`  out  1  block can accept this cycle (registered)
- `out_data`  out  `WIDTH`  selected word
- `out_sel`  out  `SEL_W`  index that produced `out_data`
- `out_valid`  out  1  `out_data`/`out_sel` valid
- `out_ready`  in  1  downstream consumes this cycle
- `sel_err`  out  1  sticky: an accepted `in_sel` was ≥ `NUM_IN`
- `sel_err_clr`  in  1  synchronous clear of `sel_err`

## Operation
- Accept = `in_valid && in_ready && !flush`. Consume = `out_valid && out_ready`.
- Captured entry = {selected channel word, `in_sel`}.
  - If `in_sel` ≥ `NUM_IN`, the word is all zeros and the entry is still accepted/forwarded.
  - `sel_err` sets on the following edge.
- Storage: main register (drives outputs) plus one skid register.
- States:
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - FULL: `out_valid`=1, skid empty, `in_ready`=1.
  - SKID: `out_valid`=1, skid holds the next entry, `in_ready`=0.
- Transitions:
  - EMPTY: accept → FULL (main←in).
  - FULL:
    - accept & consume → FULL (main←in).
    - accept & !consume → SKID (skid←in).
    - !accept & consume → EMPTY.
    - else hold.
  - SKID: consume → FULL (main←skid); else hold.
- `in_ready` is registered and equals (next state ≠ SKID).
- Ordering is strictly FIFO; no entry is dropped or duplicated except by flush/reset.
- Stability: while `out_valid && !out_ready`, `out_data`/`out_sel` hold.
- Flush:
  - Next state is EMPTY and `in_ready` is 1 next cycle.
  - Overrides accept and consume in the same cycle; the offered input is dropped.
  - Does not affect `sel_err`.
- `sel_err`: a set and `sel_err_clr` in the same cycle → set wins.
- Reset (async, any state, mid-transfer):
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `sel_err`=0, `in_ready`=1, state EMPTY, skid contents don't-care.
  - `in_valid` is ignored while `rst` is high.
- Power-of-two `NUM_IN`: the out-of-range path is unreachable and `sel_err` stays 0.

## Timing
- Latency: accept at edge n → `out_valid`=1 with the entry after edge n (visible in cycle n+1), when EMPTY or FULL with consume.
- Throughput: 1 entry/cycle with `out_ready` held high.
- Backpressure:
  - `out_ready` low for one cycle in FULL with `in_valid` high → SKID; `in_ready` drops one cycle later.
  - The in-flight word is kept in skid, not lost.
- Recovery: from SKID, `out_ready` high → `in_ready`=1 after that edge; the skid entry is output the next cycle.
- `sel_err` asserts one cycle after the offending accept.
- All outputs are flop-driven. The only combinational path is `in_data`/`in_sel` → capture registers.

## Test plan
- Reset then stream: `NUM_IN`=8, `WIDTH`=64, channel k = `64'hA0A0_0000_0000_000k`, `in_sel`=0..7 on consecutive cycles, `out_ready`=1 → outputs appear in order one cycle later, `out_sel` 0..7, `in_ready` stays 1.
- Backpressure:
  - Stream sel=3,5,6; drop `out_ready` on the cycle sel=5 is accepted → SKID, `in_ready`=0.
  - sel=3 data held stable.
  - On `out_ready`=1, outputs are 3,5,6 with none lost or duplicated.
- Out-of-range: `NUM_IN`=5, accept `in_sel`=6 → `out_data`=0, `out_sel`=6, `sel_err`=1 next cycle and holds.
  - `sel_err_clr` alone clears it.
  - `sel_err_clr` with a new sel=7 accept keeps it at 1.
- Flush in SKID with `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1; the flushed and offered entries never appear.
- Async reset mid-stream (asserted between edges, in SKID) → `out_valid`, `out_data`, `out_sel`, `sel_err` are 0 immediately and `in_ready`=1.
  - First post-reset accept appears one cycle later.
- Random `in_valid`/`out_ready` (10k cycles, `NUM_IN`=8 and 5) → scoreboard matches the output sequence to the accepted sequence, and outputs are stable whenever stalled.
